mac_accumulator: RTL and testbench

//  Streaming signed multiply-accumulate stage of the AI core datapath; consumes operand

---
 rtl/ai_core_pkg.sv | 19 +
 rtl/mac_accumulator_sign_extender.sv | 17 +
 rtl/mac_accumulator.sv | 227 ++++++++++++++++++++++
 tb/tb_mac_accumulator.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_core_pkg.sv
// Shared constants and types for the AI core datapath blocks.
package ai_core_pkg;

  // Default operand, accumulator and beat-counter widths.
  localparam int unsigned IN_SIZE_DEF  = 8;
  localparam int unsigned ACC_SIZE_DEF = 32;
  localparam int unsigned CNT_W_DEF    = 16;

  // Signed operand and accumulator types at the default widths.
  typedef logic signed [IN_SIZE_DEF-1:0]  operand_t;
  typedef logic signed [ACC_SIZE_DEF-1:0] acc_t;

  // Accumulator control state. IDLE means the next beat starts a new vector.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } mac_state_e;

endpackage : ai_core_pkg

// File: rtl/mac_accumulator_sign_extender.sv
// Widens a two's-complement value by replicating its sign bit.
module sign_extender #(
  parameter int unsigned IN_SIZE  = 16,
  parameter int unsigned OUT_SIZE = 32
) (
  input  logic [IN_SIZE-1:0]  i_data,
  output logic [OUT_SIZE-1:0] o_data
);

  if (OUT_SIZE > IN_SIZE) begin : g_extend
    assign o_data = {{(OUT_SIZE-IN_SIZE){i_data[IN_SIZE-1]}}, i_data};
  end else begin : g_pass
    // Equal widths: nothing to extend.
    assign o_data = i_data[OUT_SIZE-1:0];
  end

endmodule : sign_extender

// File: rtl/mac_accumulator.sv
// Streaming signed multiply-accumulate stage.
// Stage 1 registers the operand product, stage 2 accumulates it into a
// per-vector sum, and an output register presents one result per vector
// with its beat count and a sticky overflow flag. A full output register
// that is not being accepted stalls the whole pipe.
module mac_accumulator
  import ai_core_pkg::*;
#(
  parameter int unsigned IN_SIZE  = IN_SIZE_DEF,
  parameter int unsigned ACC_SIZE = ACC_SIZE_DEF,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  a_i,
  input  logic [IN_SIZE-1:0]  b_i,
  input  logic                last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] out_data_o,
  output logic [CNT_W-1:0]    out_count_o,
  output logic                out_ovf_o
);

  localparam int unsigned PROD_W = 2 * IN_SIZE;

  // Clamp limits used when the accumulator overflows in saturating mode.
  localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  // The full product must fit the accumulator without truncation.
  if (ACC_SIZE < PROD_W) begin : g_size_check
    $error("mac_accumulator: ACC_SIZE must be >= 2*IN_SIZE");
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_en;
  logic w_fire;
  logic w_s2_go;
  logic w_first;

  logic                r_s1_valid;
  logic                r_s1_last;
  logic [PROD_W-1:0]   r_s1_prod;
  logic [PROD_W-1:0]   w_a_ext;
  logic [PROD_W-1:0]   w_b_ext;
  logic [PROD_W-1:0]   w_prod;

  logic [ACC_SIZE-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_sticky;

  logic [ACC_SIZE-1:0] w_ext;
  logic [ACC_SIZE-1:0] w_base;
  logic [ACC_SIZE:0]   w_sum;
  logic                w_ovf;
  logic [ACC_SIZE-1:0] w_acc_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_ovf_next;

  logic                r_out_valid;
  logic [ACC_SIZE-1:0] r_out_data;
  logic [CNT_W-1:0]    r_out_count;
  logic                r_out_ovf;

  mac_state_e r_state;
  mac_state_e w_state_next;

  // The pipe advances unless a result is waiting on a stalled consumer.
  assign w_en       = !(r_out_valid && !out_ready_i);
  // A beat offered together with clear_i is refused.
  assign in_ready_o = w_en && !clear_i;
  assign w_fire     = in_valid_i && in_ready_o;
  // A stage-1 beat reaches the accumulator only when the pipe moves and it
  // is not being discarded by clear_i in the same cycle.
  assign w_s2_go    = w_en && r_s1_valid && !clear_i;

  // ---------------------------------------------------------------------------
  // Stage 1: signed product
  // ---------------------------------------------------------------------------
  // Sign-extending both operands to the product width makes the low PROD_W
  // bits of a plain multiply equal to the signed product.
  assign w_a_ext = {{IN_SIZE{a_i[IN_SIZE-1]}}, a_i};
  assign w_b_ext = {{IN_SIZE{b_i[IN_SIZE-1]}}, b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  // Stage-1 register: capture product and last flag whenever the pipe moves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_fire;
      r_s1_last  <= last_i;
      r_s1_prod  <= w_prod;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate
  // ---------------------------------------------------------------------------
  sign_extender #(
    .IN_SIZE  (PROD_W),
    .OUT_SIZE (ACC_SIZE)
  ) u_sign_extender (
    .i_data (r_s1_prod),
    .o_data (w_ext)
  );

  // Sum one bit wider than the accumulator so overflow shows up as a
  // disagreement between the two top bits.
  assign w_base = w_first ? '0 : r_acc;
  assign w_sum  = {w_base[ACC_SIZE-1], w_base} + {w_ext[ACC_SIZE-1], w_ext};
  assign w_ovf  = w_sum[ACC_SIZE] ^ w_sum[ACC_SIZE-1];

  // Next accumulator value, overflow flag and beat count for this beat.
  always_comb begin
    // NOTE: every combinational output gets a value on every path (here via
    // the leading default) so no latch is inferred.
    w_acc_next = w_sum[ACC_SIZE-1:0];
    if (w_ovf && SATURATE) begin
      w_acc_next = w_sum[ACC_SIZE] ? ACC_MIN : ACC_MAX;
    end
    w_ovf_next = w_first ? w_ovf : (r_ovf_sticky | w_ovf);
    if (w_first) begin
      w_cnt_next = CNT_W'(1);
    end else if (&r_cnt) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Accumulator registers: zeroed on abort, updated on each stage-2 beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (clear_i) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (w_s2_go) begin
      r_acc        <= w_acc_next;
      r_cnt        <= w_cnt_next;
      r_ovf_sticky <= w_ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector FSM: IDLE (next beat starts a vector) / ACCUM (partial sum live)
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_s2_go && !r_s1_last) begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (clear_i || (w_s2_go && r_s1_last)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State outputs.
  always_comb begin
    w_first = (r_state == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Load on a last beat (even in the cycle the previous result is accepted),
  // otherwise drop the result once the consumer takes it. clear_i leaves a
  // pending result untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_s2_go && r_s1_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_next;
      r_out_count <= w_cnt_next;
      r_out_ovf   <= w_ovf_next;
    end else if (r_out_valid && out_ready_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_count_o = r_out_count;
  assign out_ovf_o   = r_out_ovf;

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator. The main instance uses default
// parameters and is checked by a scoreboard; two 16-bit instances (saturate
// and wrap) share the same stimulus for the overflow scenario.
module tb_mac_accumulator;

  typedef struct {
    int data;
    int count;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        last;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_ovf;

  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [15:0] out_data_s, out_count_s;
  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [15:0] out_data_w, out_count_w;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .last_i(last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_count_o(out_count), .out_ovf_o(out_ovf)
  );

  mac_accumulator #(.IN_SIZE(8), .ACC_SIZE(16), .SATURATE(1'b1), .CNT_W(16)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .a_i(a), .b_i(b), .last_i(last),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready),
    .out_data_o(out_data_s), .out_count_o(out_count_s), .out_ovf_o(out_ovf_s)
  );

  mac_accumulator #(.IN_SIZE(8), .ACC_SIZE(16), .SATURATE(1'b0), .CNT_W(16)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w),
    .a_i(a), .b_i(b), .last_i(last),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready),
    .out_data_o(out_data_w), .out_count_o(out_count_w), .out_ovf_o(out_ovf_w)
  );

  // Reference model of one vector: signed MAC with per-beat saturate/wrap.
  function automatic exp_t model(input int qa[$], input int qb[$], input int acc_w, input bit sat);
    exp_t   e;
    longint acc = 0;
    longint hi  = (longint'(1) <<< (acc_w - 1)) - 1;
    longint lo  = -hi - 1;
    longint s;
    e.ovf = 1'b0;
    for (int i = 0; i < qa.size(); i++) begin
      s = acc + longint'(qa[i]) * longint'(qb[i]);
      if (s > hi || s < lo) begin
        e.ovf = 1'b1;
        if (sat) begin
          s = (s > hi) ? hi : lo;
        end else begin
          s = s & ((longint'(1) <<< acc_w) - 1);
          if (s > hi) s = s - (longint'(1) <<< acc_w);
        end
      end
      acc = s;
    end
    e.data  = int'(acc);
    e.count = qa.size();
    return e;
  endfunction

  // Scoreboard: compare every accepted result of the main instance.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got data=%0d count=%0d ovf=%0b, no result expected",
                 $signed(out_data), out_count, out_ovf);
      end else begin
        e = sb.pop_front();
        if ($signed(out_data) !== e.data || out_count !== e.count[15:0] || out_ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL sb_result: got data=%0d count=%0d ovf=%0b, expected data=%0d count=%0d ovf=%0b",
                   $signed(out_data), out_count, out_ovf, e.data, e.count, e.ovf);
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic put_beat(input int av, input int bv, input bit lst);
    int guard = 0;
    in_valid = 1'b1;
    a        = av[7:0];
    b        = bv[7:0];
    last     = lst;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL beat_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  // Push the model result, then stream the vector back-to-back.
  task automatic send_vector(input int qa[$], input int qb[$]);
    sb.push_back(model(qa, qb, 32, 1'b1));
    for (int i = 0; i < qa.size(); i++) begin
      put_beat(qa[i], qb[i], i == qa.size() - 1);
    end
  endtask

  // Wait (bounded) until all expected results have been observed.
  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; last = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d count=%0d ovf=%0b, required all 0",
               out_valid, out_data, out_count, out_ovf);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_basic_vector();
    int qa[$];
    int qb[$];
    @(posedge clk); #1;
    qa = '{3, -2, 7};
    qb = '{4, 5, -1};
    send_vector(qa, qb);
    // Last beat was accepted at the previous edge: one cycle in stage 1 first.
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%0b one cycle after last beat, required 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_t2: out_valid=%0b two cycles after last beat, required 1", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_single_beat();
    int qa[$];
    int qb[$];
    qa = '{-128};
    qb = '{-128};
    send_vector(qa, qb);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int qa[$];
    int qb[$];
    qa = '{1, 2};
    qb = '{1, 1};
    send_vector(qa, qb);
    qa = '{-3};
    qb = '{5};
    send_vector(qa, qb);
    qa = '{127, -128, 100, -7};
    qb = '{-128, -128, 99, 3};
    send_vector(qa, qb);
    wait_drain();
  endtask

  task automatic test_saturate();
    int qa[$];
    int qb[$];
    int guard = 0;
    exp_t es;
    exp_t ew;
    qa = '{127, 127, 127};
    qb = '{127, 127, 127};
    es = model(qa, qb, 16, 1'b1);
    ew = model(qa, qb, 16, 1'b0);
    send_vector(qa, qb);
    @(negedge clk);
    while (!out_valid_s && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!out_valid_s) begin
      n_fail++;
      $display("FAIL sat_timeout: no result from 16-bit instances after %0d cycles", guard);
    end else begin
      if ($signed(out_data_s) !== es.data || out_ovf_s !== es.ovf || out_count_s !== es.count[15:0]) begin
        n_fail++;
        $display("FAIL sat_clamp: got data=%0d ovf=%0b count=%0d, expected data=%0d ovf=%0b count=%0d",
                 $signed(out_data_s), out_ovf_s, out_count_s, es.data, es.ovf, es.count);
      end
      n_checks++;
      if ($signed(out_data_w) !== ew.data || out_ovf_w !== ew.ovf || out_valid_w !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_result: got data=%0d ovf=%0b valid=%0b, expected data=%0d ovf=%0b valid=1",
                 $signed(out_data_w), out_ovf_w, out_valid_w, ew.data, ew.ovf);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int qa[$];
    int qb[$];
    out_ready = 1'b0;
    qa = '{5};
    qb = '{6};
    send_vector(qa, qb);
    qa = '{7};
    qb = '{8};
    send_vector(qa, qb);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || $signed(out_data) !== 30) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got in_ready=%0b valid=%0b data=%0d, required 0/1/30",
                 i, in_ready, out_valid, $signed(out_data));
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_clear();
    int qa[$];
    int qb[$];
    put_beat(5, 5, 1'b0);
    put_beat(6, 6, 1'b0);
    // Abort while beat 2 sits in stage 1; offer a beat that must be refused.
    clear = 1'b1; in_valid = 1'b1; a = 8'd77; b = 8'd77; last = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_in_ready: got %0b during clear, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0; last = 1'b0;
    qa = '{2};
    qb = '{3};
    send_vector(qa, qb);
    wait_drain();
  endtask

  task automatic test_reset_mid_vector();
    int qa[$];
    int qb[$];
    // Leave a result pending and a partial vector in flight, then reset.
    out_ready = 1'b0;
    put_beat(9, 9, 1'b1);
    put_beat(4, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%0b data=%0d count=%0d ovf=%0b, required all 0",
               out_valid, out_data, out_count, out_ovf);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    qa = '{1, 2};
    qb = '{3, 4};
    send_vector(qa, qb);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic_vector();
    test_single_beat();
    test_back_to_back();
    test_saturate();
    test_backpressure();
    test_clear();
    test_reset_mid_vector();
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d results never observed, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_mac_accumulator
